// File: rtl/panda_pulse_pkg.sv
// Shared constants, entry layout and sizing helper for the pulse measurement block.
package panda_pulse_pkg;

    localparam int unsigned CNT_W_C    = 48;
    localparam int unsigned MISSED_W_C = 32;

    // One measured pulse; gap occupies the upper half of the packed FIFO word.
    typedef struct packed {
        logic [CNT_W_C-1:0] gap;
        logic [CNT_W_C-1:0] width;
    } entry_t;

    // Occupancy counter width: must be able to represent DEPTH itself.
    function automatic int unsigned queue_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/panda_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with synchronous clear.
// A write into a full FIFO is accepted only when a read pops in the same cycle.
module panda_fifo_fwft
    import panda_pulse_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 96
) (
    input  logic                       clk_i,
    input  logic                       clr_i,
    input  logic                       wr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [queue_w(DEPTH)-1:0]  count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = queue_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_wr, do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // Head word is presented whenever not empty; zero otherwise.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pop only real data; a push to a full FIFO needs a simultaneous pop.
    always_comb begin
        do_rd    = rd_i & ~empty_o;
        do_wr    = wr_i & (~full_o | do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates the output.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/panda_pulse_meas.sv
// Pulse train measurement: records {gap, width} of every complete pulse on inp_i
// into a FWFT FIFO and reports drops and counter saturation.
module panda_pulse_meas
    import panda_pulse_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CNT_W = CNT_W_C
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       inp_i,
    input  logic                       rd_i,
    input  logic                       FORCE_RST,
    output logic                       valid_o,
    output logic [CNT_W-1:0]           GAP_O,
    output logic [CNT_W-1:0]           WIDTH_O,
    output logic [queue_w(DEPTH)-1:0]  QUEUE,
    output logic [MISSED_W_C-1:0]      MISSED_CNT,
    output logic                       ERR_OVERFLOW,
    output logic                       ERR_SAT
);

    localparam logic [CNT_W-1:0]      CntMax    = {CNT_W{1'b1}};
    localparam logic [MISSED_W_C-1:0] MissedMax = {MISSED_W_C{1'b1}};

    logic                  clr;
    logic                  inp_q;
    logic                  armed_q;
    logic [CNT_W-1:0]      low_q, low_d;
    logic [CNT_W-1:0]      high_q, high_d;
    logic [CNT_W-1:0]      gap_q, gap_d;
    logic                  push_q, push_d;
    logic [2*CNT_W-1:0]    push_data_q, push_data_d;
    logic [MISSED_W_C-1:0] missed_q, missed_d;
    logic                  ovf_q, ovf_d;
    logic                  sat_q, sat_d;
    logic                  rise, fall, pop, miss;

    logic                  fifo_full, fifo_empty;
    logic [2*CNT_W-1:0]    fifo_rd_data;
    logic [queue_w(DEPTH)-1:0] fifo_count;

    assign clr = rst_i | FORCE_RST;

    // Edge detection, run-length counting and error bookkeeping.
    always_comb begin
        rise        = inp_i & ~inp_q & armed_q;
        fall        = ~inp_i & inp_q & armed_q;
        low_d       = low_q;
        high_d      = high_q;
        gap_d       = gap_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (rise) begin
            gap_d  = low_q;
            low_d  = '0;
            high_d = CNT_W'(1);
        end else if (fall) begin
            push_d      = 1'b1;
            push_data_d = {gap_q, high_q};
            high_d      = '0;
            low_d       = CNT_W'(1);
        end else if (inp_i) begin
            if (high_q != CntMax) begin
                high_d = high_q + 1'b1;
            end
        end else begin
            if (low_q != CntMax) begin
                low_d = low_q + 1'b1;
            end
        end
        sat_d = sat_q | (low_d == CntMax) | (high_d == CntMax);

        // The push request from the previous edge is resolved against the FIFO now.
        pop      = rd_i & ~fifo_empty;
        miss     = push_q & fifo_full & ~pop;
        missed_d = missed_q;
        if (miss && (missed_q != MissedMax)) begin
            missed_d = missed_q + 1'b1;
        end
        ovf_d = ovf_q | miss;
    end

    // Measurement state; rst_i and FORCE_RST both discard everything in flight.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            inp_q       <= 1'b0;
            armed_q     <= 1'b0;
            low_q       <= '0;
            high_q      <= '0;
            gap_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            missed_q    <= '0;
            ovf_q       <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            inp_q       <= inp_i;
            armed_q     <= armed_q | ~inp_i;
            low_q       <= low_d;
            high_q      <= high_d;
            gap_q       <= gap_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            missed_q    <= missed_d;
            ovf_q       <= ovf_d;
            sat_q       <= sat_d;
        end
    end

    panda_fifo_fwft #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * CNT_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .clr_i     (clr),
        .wr_i      (push_q),
        .wr_data_i (push_data_q),
        .rd_i      (rd_i),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign valid_o      = ~fifo_empty;
    assign GAP_O        = fifo_rd_data[2*CNT_W-1:CNT_W];
    assign WIDTH_O      = fifo_rd_data[CNT_W-1:0];
    assign QUEUE        = fifo_count;
    assign MISSED_CNT   = missed_q;
    assign ERR_OVERFLOW = ovf_q;
    assign ERR_SAT      = sat_q;

endmodule

// File: tb/tb_panda_pulse_meas.sv
// Bench for panda_pulse_meas with a small FIFO and narrow counters; pulses are
// described as (gap, width) pairs and expected entries come from those pairs.
module tb_panda_pulse_meas;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned MAXC  = 255;

    logic             clk = 1'b0;
    logic             rst_i, inp_i, rd_i, force_rst;
    logic             valid_o, err_ovf, err_sat;
    logic [CNT_W-1:0] gap_o, width_o;
    logic [2:0]       queue;
    logic [31:0]      missed;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [15:0] mq[$];
    int unsigned m_missed;
    bit          m_ovf, m_sat;
    bit          pend, exp_open;
    logic [15:0] pend_e, exp_e;
    int          run_len;
    logic        last_inp;
    int          rd_pct;

    panda_pulse_meas #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .inp_i        (inp_i),
        .rd_i         (rd_i),
        .FORCE_RST    (force_rst),
        .valid_o      (valid_o),
        .GAP_O        (gap_o),
        .WIDTH_O      (width_o),
        .QUEUE        (queue),
        .MISSED_CNT   (missed),
        .ERR_OVERFLOW (err_ovf),
        .ERR_SAT      (err_sat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        return (v > int'(MAXC)) ? 8'(MAXC) : 8'(v);
    endfunction

    function automatic logic rnd_rd();
        return ($urandom_range(99) < rd_pct) ? 1'b1 : 1'b0;
    endfunction

    // One clock: drive, let the DUT sample, advance the model, compare everything.
    task automatic tick(input logic inp, input logic rd, input logic rst, input logic frst);
        bit popped;
        rst_i     = rst;
        force_rst = frst;
        inp_i     = inp;
        rd_i      = rd;
        @(posedge clk);
        #1;
        if (rst || frst) begin
            mq.delete();
            m_missed = 0;
            m_ovf    = 0;
            m_sat    = 0;
            pend     = 0;
            exp_open = 0;
            run_len  = 0;
        end else begin
            popped = rd && (mq.size() > 0);
            if (popped) void'(mq.pop_front());
            if (pend) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(pend_e);
                end else begin
                    if (m_missed != 32'hFFFF_FFFF) m_missed++;
                    m_ovf = 1;
                end
            end
            pend = 0;
            if (inp == 1'b0 && exp_open) begin
                pend     = 1;
                pend_e   = exp_e;
                exp_open = 0;
            end
            if (run_len > 0 && inp == last_inp) run_len++;
            else run_len = 1;
            last_inp = inp;
            if (run_len >= int'(MAXC)) m_sat = 1;
        end
        check_eq("valid", valid_o, (mq.size() > 0));
        check_eq("queue", queue, mq.size());
        check_eq("missed", missed, m_missed);
        check_eq("err_overflow", err_ovf, m_ovf);
        check_eq("err_sat", err_sat, m_sat);
        if (mq.size() > 0) begin
            check_eq("gap", gap_o, mq[0][15:8]);
            check_eq("width", width_o, mq[0][7:0]);
        end
    endtask

    task automatic do_reset(input logic use_force, input logic lvl);
        tick(lvl, 1'b0, ~use_force, use_force);
    endtask

    // g low cycles then w high cycles; the entry closes on the next low cycle.
    task automatic pulse(input int g, input int w);
        for (int i = 0; i < g; i++) tick(1'b0, rnd_rd(), 1'b0, 1'b0);
        for (int i = 0; i < w; i++) tick(1'b1, rnd_rd(), 1'b0, 1'b0);
        exp_open = 1;
        exp_e    = {sat8(g), sat8(w)};
    endtask

    initial begin
        int   g, w;
        logic lvl;
        rd_pct = 0;
        run_len = 0;
        last_inp = 1'b0;

        // Reset state and a single simple pulse.
        do_reset(1'b0, 1'b0);
        check_eq("rst_gap_zero", gap_o, 0);
        check_eq("rst_width_zero", width_o, 0);
        pulse(10, 5);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t1_valid_at_fall", valid_o, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t1_gap", gap_o, 10);
        check_eq("t1_width", width_o, 5);
        check_eq("t1_queue", queue, 1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t1_queue_after_rd", queue, 0);

        // Input high across reset release is not measured.
        do_reset(1'b0, 1'b1);
        repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(3, 4);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t2_queue", queue, 1);
        check_eq("t2_gap", gap_o, 3);
        check_eq("t2_width", width_o, 4);

        // Overflow with no reads.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) pulse(2, 2 + k);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t3_queue", queue, 4);
        check_eq("t3_missed", missed, 2);
        check_eq("t3_ovf", err_ovf, 1);
        for (int k = 0; k < 4; k++) begin
            check_eq("t3_read_gap", gap_o, 2);
            check_eq("t3_read_width", width_o, 2 + k);
            tick(1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Full FIFO, push and pop in the same cycle.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) pulse(2, 3 + k);
        pulse(2, 9);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t4_full", queue, 4);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t4_queue", queue, 4);
        check_eq("t4_missed", missed, 0);
        for (int k = 0; k < 4; k++) begin
            check_eq("t4_read_width", width_o, (k == 3) ? 9 : 4 + k);
            tick(1'b0, 1'b1, 1'b0, 1'b0);
        end

        // FORCE_RST mid-pulse with entries queued.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) pulse(2, 3);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t5_queued", queue, 3);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        check_eq("t5_queue", queue, 0);
        check_eq("t5_missed", missed, 0);
        check_eq("t5_flags", {err_ovf, err_sat}, 0);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(4, 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t5_new_queue", queue, 1);
        check_eq("t5_new_gap", gap_o, 4);
        check_eq("t5_new_width", width_o, 2);

        // Gap counter saturation.
        do_reset(1'b0, 1'b0);
        pulse(300, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_gap", gap_o, 255);
        check_eq("t6_width", width_o, 1);
        check_eq("t6_sat", err_sat, 1);
        pulse(3, 3);
        check_eq("t6_sat_sticky", err_sat, 1);
        do_reset(1'b0, 1'b0);
        check_eq("t6_sat_cleared", err_sat, 0);

        // Randomized pulse trains, read rates and occasional resets.
        for (int it = 0; it < 80; it++) begin
            rd_pct = $urandom_range(90);
            if ($urandom_range(24) == 0) begin
                lvl = 1'($urandom_range(1));
                do_reset(1'($urandom_range(1)), lvl);
                repeat ($urandom_range(3)) tick(lvl, rnd_rd(), 1'b0, 1'b0);
            end
            g = ($urandom_range(9) == 0) ? int'($urandom_range(250, 270)) : int'($urandom_range(1, 5));
            w = ($urandom_range(9) == 0) ? int'($urandom_range(250, 270)) : int'($urandom_range(1, 5));
            pulse(g, w);
        end
        rd_pct = 100;
        repeat (8) tick(1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
